// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder with a byte-stream handshake, oversampled in the clk domain
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sck, ss_n, mosi     raw SPI pins from the external master (asynchronous to clk)
//   miso, miso_oe       slave-out data and its output enable (tristated at top level)
//   tx_data/tx_valid    next word to transmit, written when tx_ready is high
//   tx_ready            TX holding register empty
//   rx_data/rx_valid    last received word, rx_valid pulses for one cycle on update
//   tx_underrun         one-cycle pulse when a word is needed but none is queued
//   busy                frame in progress
module spi_slave #(
  parameter int              DATA_W      = 8,
  parameter logic [DATA_W-1:0] TX_IDLE   = 8'hFF,
  parameter int              SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   ss_d;

  logic [0:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;

  logic              sck_s;
  logic              ss_s;
  logic              mosi_s;
  logic              rise;
  logic              fall;
  logic              ss_fall;
  logic              ss_rise;
  logic              tx_wr;
  logic              consume;
  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] rx_next;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rise    =  sck_s & ~sck_d;
  assign fall    = ~sck_s &  sck_d;
  assign ss_fall = ~ss_s  &  ss_d;
  assign ss_rise =  ss_s  & ~ss_d;

  assign tx_ready = ~hold_full;
  assign tx_wr    = tx_valid & tx_ready;

  // Holding register is drained at frame start and on the fall that follows
  // a completed word. A deselect in the same cycle takes priority over the fall.
  assign consume = ((state == ST_IDLE) & ss_fall) |
                   ((state == ST_ACTIVE) & ~ss_rise & fall & (bit_cnt == '0));

  assign next_word = hold_full ? hold_data : TX_IDLE;
  assign rx_next   = {rx_shift, mosi_s};

  assign miso    = tx_shift[DATA_W-1];
  assign miso_oe = (state == ST_ACTIVE);
  assign busy    = (state == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync    <= '0;
      ss_sync     <= '1;
      mosi_sync   <= '0;
      sck_d       <= 1'b0;
      ss_d        <= 1'b1;
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;

      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // A write that lands while an empty register is being consumed stays
      // queued for the next word; the current consumer gets TX_IDLE.
      if (consume) begin
        if (hold_full) begin
          hold_full <= 1'b0;
        end else begin
          tx_underrun <= 1'b1;
          if (tx_wr) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
          end
        end
      end else if (tx_wr) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state    <= ST_ACTIVE;
            bit_cnt  <= '0;
            tx_shift <= next_word;
          end
        end
        default: begin
          if (ss_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (rise) begin
            rx_shift <= rx_next[DATA_W-2:0];
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (fall) begin
            if (bit_cnt == '0) begin
              tx_shift <= next_word;
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_log [64];
  int         rx_cnt = 0;
  int         ur_cnt = 0;

  spi_slave #(
    .DATA_W      (8),
    .TX_IDLE     (8'hFF),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_cnt < 64) rx_log[rx_cnt] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_underrun) ur_cnt = ur_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic refill(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("refill_ready", tx_ready, 1);
    push_tx(d);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high(input int half);
    repeat (half) @(negedge clk);
    ss_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  task automatic xfer(input int nbits, input logic [31:0] mo, input int half,
                      output logic [31:0] mi);
    mi = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = mo[i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      mi  = {mi[30:0], miso};
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  logic [31:0] got_mi;
  int          rx_base;
  int          ur_base;
  int          waited;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso",        miso,        0);
    check("rst_miso_oe",     miso_oe,     0);
    check("rst_rx_data",     rx_data,     0);
    check("rst_rx_valid",    rx_valid,    0);
    check("rst_tx_ready",    tx_ready,    1);
    check("rst_tx_underrun", tx_underrun, 0);
    check("rst_busy",        busy,        0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // single frame with a queued word
    push_tx(8'h3C);
    check("t1_ready_low", tx_ready, 0);
    rx_base = rx_cnt;
    ss_low();
    check("t1_ready_back", tx_ready, 1);
    check("t1_busy", busy, 1);
    xfer(8, 32'hA5, 6, got_mi);
    check("t1_miso_word", got_mi, 32'h3C);
    ss_high(6);
    check("t1_rx_cnt", rx_cnt - rx_base, 1);
    check("t1_rx_data", rx_log[rx_base], 8'hA5);

    // nothing queued: idle word and an underrun pulse at frame start
    rx_base = rx_cnt;
    ur_base = ur_cnt;
    ss_low();
    xfer(8, 32'h00, 6, got_mi);
    check("t2_urun_cnt", ur_cnt - ur_base, 1);
    check("t2_miso_word", got_mi, 32'hFF);
    ss_high(6);
    check("t2_rx_cnt", rx_cnt - rx_base, 1);
    check("t2_rx_data", rx_log[rx_base], 8'h00);

    // three-word burst with refills
    push_tx(8'h81);
    rx_base = rx_cnt;
    ur_base = ur_cnt;
    ss_low();
    fork
      xfer(24, 32'h112233, 6, got_mi);
      begin
        refill(8'h82);
        refill(8'h83);
      end
    join
    check("t3_urun_cnt", ur_cnt - ur_base, 0);
    check("t3_miso_word", got_mi, 32'h818283);
    ss_high(6);
    check("t3_rx_cnt", rx_cnt - rx_base, 3);
    check("t3_rx0", rx_log[rx_base],     8'h11);
    check("t3_rx1", rx_log[rx_base + 1], 8'h22);
    check("t3_rx2", rx_log[rx_base + 2], 8'h33);

    // abort after five bits, then a clean frame
    rx_base = rx_cnt;
    ss_low();
    xfer(5, 32'h1E, 6, got_mi);
    repeat (6) @(negedge clk);
    ss_n = 1'b1;
    waited = 0;
    while (miso_oe && waited < SYNC + 2) begin
      @(negedge clk);
      waited++;
    end
    check("t4_miso_oe_drop", miso_oe, 0);
    repeat (SYNC + 4) @(negedge clk);
    check("t4_no_rx", rx_cnt - rx_base, 0);
    ss_low();
    xfer(8, 32'h5A, 6, got_mi);
    check("t4_miso_word", got_mi, 32'hFF);
    ss_high(6);
    check("t4_rx_cnt", rx_cnt - rx_base, 1);
    check("t4_rx_data", rx_log[rx_base], 8'h5A);

    // reset mid-frame discards the queued word
    ss_low();
    push_tx(8'h77);
    check("t5_ready_low", tx_ready, 0);
    xfer(4, 32'hF, 6, got_mi);
    reset = 1'b1;
    ss_n  = 1'b1;
    @(negedge clk);
    check("t5_miso",        miso,        0);
    check("t5_miso_oe",     miso_oe,     0);
    check("t5_busy",        busy,        0);
    check("t5_tx_ready",    tx_ready,    1);
    check("t5_rx_data",     rx_data,     0);
    check("t5_rx_valid",    rx_valid,    0);
    check("t5_tx_underrun", tx_underrun, 0);
    reset = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    rx_base = rx_cnt;
    ss_low();
    xfer(8, 32'h00, 6, got_mi);
    check("t5_miso_word", got_mi, 32'hFF);
    ss_high(6);
    check("t5_rx_cnt", rx_cnt - rx_base, 1);

    // fastest SCK, 16-bit transfer as two words
    push_tx(8'hCA);
    rx_base = rx_cnt;
    ss_low();
    fork
      xfer(16, 32'hBEEF, 4, got_mi);
      refill(8'hFE);
    join
    check("t6_miso_word", got_mi, 32'hCAFE);
    ss_high(4);
    check("t6_rx_cnt", rx_cnt - rx_base, 2);
    check("t6_rx0", rx_log[rx_base],     8'hBE);
    check("t6_rx1", rx_log[rx_base + 1], 8'hEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first). It is the far end of the SPI master used in SYSTEM.
- Lets the FPGA act as a peripheral to an external SPI master, e.g. a host MCU reading datalogger samples.
- Runs entirely in the system clk domain. SCK/SS/MOSI are oversampled through synchronizers.
- Exposes a byte-stream handshake to the bus-side peripheral register logic.
- MISO is tristated at top level through an SB_IO, using miso_oe.

Parameters:
DATA_W, 8, bits per SPI word
TX_IDLE, 8'hFF, word shifted out when no TX data is queued
SYNC_STAGES, 2, synchronizer flip-flops on each SPI input (≥2)

Ports:
clk  input  1  system clock (25 MHz); SCK must be ≤ clk/8
reset  input  1  synchronous, active-high reset
sck  input  1  SPI clock from external master
ss_n  input  1  slave select, active low
mosi  input  1  master-out data
miso  output  1  slave-out data
miso_oe  output  1  MISO output enable, high while selected
tx_data  input  DATA_W  next word to transmit
tx_valid  input  1  tx_data offered
tx_ready  output  1  TX holding register empty
rx_data  output  DATA_W  last received word
rx_valid  output  1  one-cycle pulse, rx_data updated
tx_underrun  output  1  one-cycle pulse, word boundary reached with holding register empty
busy  output  1  frame in progress (synchronized ss_n low)

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0. Bit counter=0, holding register empty, synchronizers preset to ss_n=1, sck=0, mosi=0.
- Reset is honoured mid-frame: all state returns to reset values. The partial word and any queued TX word are discarded.
- Inputs pass through SYNC_STAGES flops plus one edge-detect flop.
  - rise = sck_s & ~sck_d; fall = ~sck_s & sck_d; ss_fall / ss_rise are defined likewise.
  - Edge events act SYNC_STAGES+1 clk cycles after the pin transition.
- TX holding register:
  - A write occurs when tx_valid & tx_ready; tx_ready deasserts the next cycle.
  - The register is consumed on frame start and at each word boundary; tx_ready reasserts the cycle after consumption.
  - Write and consume in the same cycle while empty: the consumer gets TX_IDLE, tx_underrun pulses, and the written word stays queued.
- States:
  - IDLE: miso_oe=0, busy=0.
    - On ss_fall: bit_cnt←0, tx_shift←holding word (or TX_IDLE with tx_underrun pulse), go to ACTIVE.
    - miso = tx_shift[DATA_W-1] is valid the cycle after ss_fall.
  - ACTIVE: miso_oe=1, busy=1.
    - rise: rx_shift←{rx_shift[DATA_W-2:0], mosi_s}, bit_cnt←bit_cnt+1.
    - Word completes on the rise where bit_cnt==DATA_W-1:
      - rx_data←{rx_shift[DATA_W-2:0], mosi_s}.
      - rx_valid pulses in the same cycle as the rx_data update.
      - bit_cnt wraps to 0.
    - fall with bit_cnt==0 (after wrap): tx_shift←next holding word (or TX_IDLE plus tx_underrun pulse).
    - fall with bit_cnt≠0: tx_shift←tx_shift<<1.
    - The first fall of a frame has bit_cnt=1, so it shifts.
    - ss_rise: return to IDLE, bit_cnt←0, partial RX bits discarded (no rx_valid), TX bits already loaded are lost. miso_oe drops the cycle after ss_rise is detected.
- Simultaneous events:
  - rise and ss_rise in the same cycle: ss_rise wins and the bit is discarded.
  - sck edges while in IDLE are ignored.
- rx_valid is not back-pressured. The consumer must take rx_data within DATA_W SCK periods or it is overwritten.
- Consecutive frames need ss_n high for ≥ SYNC_STAGES+2 clk cycles.

Test Plan:
- Reset, then an 8-bit frame: master sends 0xA5 with tx_data=0x3C queued before SS falls → master receives 0x3C; rx_valid pulses once with rx_data=0xA5; tx_ready returns to 1 after frame start.
- No TX queued: frame of 0x00 → master receives 0xFF; tx_underrun pulses once at frame start; rx_data=0x00.
- 3-byte burst under one SS: master sends 0x11, 0x22, 0x33; bench refills 0x81, 0x82, 0x83 whenever tx_ready=1 → master receives 0x81, 0x82, 0x83; exactly three rx_valid pulses with the matching words; no tx_underrun after the first word.
- SS raised after 5 bits of 0xF0 → no rx_valid; miso_oe low within SYNC_STAGES+2 cycles. A following full frame of 0x5A is received correctly (bit counter resynchronised).
- Reset asserted mid-frame after 4 bits → all outputs at reset values next cycle; queued TX word discarded (tx_ready=1). Next frame returns TX_IDLE=0xFF.
- Timing margin: SCK=clk/8 with 50% duty, 16-bit transfer 0xBEEF with TX 0xCAFE queued as two words → all bits correct; rx_data=0xBE then 0xEF.
